// File: rtl/calc_sequencer_if.sv
// Bundle between the calculator sequencer and its environment: debounced
// buttons, switches, ALU handshake and the display/status outputs.
interface calc_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 3,
  parameter int IDX_W   = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1
);
  logic                     btn_enter;
  logic                     btn_back;
  logic [WIDTH-1:0]         sw_data;
  logic                     alu_done;
  logic [WIDTH-1:0]         alu_result;
  logic [1:0]               state;
  logic [IDX_W-1:0]         op_idx;
  logic [NUM_OPS*WIDTH-1:0] operands;
  logic [OP_W-1:0]          opcode;
  logic                     alu_start;
  logic [WIDTH-1:0]         result;
  logic                     result_valid;
  logic                     timeout_err;
  logic [WIDTH-1:0]         display_value;

  modport master (
    input  btn_enter, btn_back, sw_data, alu_done, alu_result,
    output state, op_idx, operands, opcode, alu_start, result,
           result_valid, timeout_err, display_value
  );

  modport slave (
    output btn_enter, btn_back, sw_data, alu_done, alu_result,
    input  state, op_idx, operands, opcode, alu_start, result,
           result_valid, timeout_err, display_value
  );
endinterface

// File: rtl/calc_sequencer.sv
// Control FSM for the switch/button calculator: captures operands and an
// opcode, runs the external ALU with a timeout, and holds the result.
module calc_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  calc_sequencer_if.master bus
);
  localparam int IDX_W = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_OPND = 2'd0,
    WAIT_OP   = 2'd1,
    EXEC      = 2'd2,
    SHOW      = 2'd3
  } state_t;

  state_t                            state_q, state_n;
  logic [IDX_W-1:0]                  idx_q, idx_n;
  logic [NUM_OPS-1:0][WIDTH-1:0]     opnd_q, opnd_n;
  logic [OP_W-1:0]                   opcode_q, opcode_n;
  logic [WIDTH-1:0]                  result_q, result_n;
  logic                              rvalid_q, rvalid_n;
  logic                              terr_q, terr_n;
  logic [CNT_W-1:0]                  cnt_q, cnt_n;
  logic                              start_q, start_n;
  logic                              enter_q, back_q;
  logic                              enter_e, back_e;

  // Edge registers come out of reset high so a button held through reset
  // release does nothing until it is released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_OPND;
      idx_q    <= '0;
      opnd_q   <= '0;
      opcode_q <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      terr_q   <= 1'b0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      enter_q  <= 1'b1;
      back_q   <= 1'b1;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      opnd_q   <= opnd_n;
      opcode_q <= opcode_n;
      result_q <= result_n;
      rvalid_q <= rvalid_n;
      terr_q   <= terr_n;
      cnt_q    <= cnt_n;
      start_q  <= start_n;
      enter_q  <= bus.btn_enter;
      back_q   <= bus.btn_back;
    end
  end

  always_comb begin
    enter_e  = bus.btn_enter & ~enter_q;
    back_e   = bus.btn_back & ~back_q;
    state_n  = state_q;
    idx_n    = idx_q;
    opnd_n   = opnd_q;
    opcode_n = opcode_q;
    result_n = result_q;
    rvalid_n = rvalid_q;
    terr_n   = terr_q;
    cnt_n    = cnt_q;
    start_n  = 1'b0;
    case (state_q)
      WAIT_OPND: begin
        // back takes priority when both buttons rise together
        if (back_e) begin
          if (idx_q != '0) idx_n = idx_q - IDX_W'(1);
        end else if (enter_e) begin
          for (int k = 0; k < NUM_OPS; k++) begin
            if (idx_q == IDX_W'(k)) opnd_n[k] = bus.sw_data;
          end
          if (idx_q == LAST_IDX) state_n = WAIT_OP;
          else                   idx_n   = idx_q + IDX_W'(1);
        end
      end
      WAIT_OP: begin
        if (back_e) begin
          state_n = WAIT_OPND;
          idx_n   = LAST_IDX;
        end else if (enter_e) begin
          opcode_n = bus.sw_data[OP_W-1:0];
          state_n  = EXEC;
          terr_n   = 1'b0;
          cnt_n    = '0;
          start_n  = 1'b1;
        end
      end
      EXEC: begin
        if (bus.alu_done) begin
          result_n = bus.alu_result;
          rvalid_n = 1'b1;
          state_n  = SHOW;
        end else if (cnt_q == CNT_LAST) begin
          result_n = '1;
          terr_n   = 1'b1;
          rvalid_n = 1'b0;
          state_n  = SHOW;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      SHOW: begin
        if (back_e) begin
          state_n  = WAIT_OP;
          rvalid_n = 1'b0;
        end else if (enter_e) begin
          state_n  = WAIT_OPND;
          idx_n    = '0;
          rvalid_n = 1'b0;
        end
      end
      default: state_n = WAIT_OPND;
    endcase
  end

  always_comb begin
    bus.display_value = '0;
    case (state_q)
      WAIT_OPND: bus.display_value = bus.sw_data;
      WAIT_OP:   bus.display_value = {{(WIDTH-OP_W){1'b0}}, bus.sw_data[OP_W-1:0]};
      EXEC:      bus.display_value = '0;
      SHOW:      bus.display_value = result_q;
      default:   bus.display_value = '0;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.op_idx       = idx_q;
  assign bus.operands     = opnd_q;
  assign bus.opcode       = opcode_q;
  assign bus.alu_start    = start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rvalid_q;
  assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a 2-operand instance (a) and a
// 3-operand instance (b) share clock, reset and stimulus.
module tb_calc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_enter = 1'b0;
  logic        btn_back = 1'b0;
  logic [15:0] sw_data = 16'h0;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  calc_sequencer_if #(.WIDTH(16), .NUM_OPS(2), .OP_W(3)) ia ();
  calc_sequencer_if #(.WIDTH(16), .NUM_OPS(3), .OP_W(3)) ib ();

  assign ia.btn_enter  = btn_enter;
  assign ia.btn_back   = btn_back;
  assign ia.sw_data    = sw_data;
  assign ia.alu_done   = alu_done;
  assign ia.alu_result = alu_result;
  assign ib.btn_enter  = btn_enter;
  assign ib.btn_back   = btn_back;
  assign ib.sw_data    = sw_data;
  assign ib.alu_done   = alu_done;
  assign ib.alu_result = alu_result;

  calc_sequencer #(.WIDTH(16), .NUM_OPS(2), .OP_W(3), .TIMEOUT(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.master)
  );

  calc_sequencer #(.WIDTH(16), .NUM_OPS(3), .OP_W(3), .TIMEOUT(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.master)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic enter, input logic [15:0] sw);
    sw_data = sw;
    if (enter) btn_enter = 1'b1;
    else       btn_back  = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    tick(1);
  endtask

  initial begin
    // reset with enter held across release
    btn_enter = 1'b1;
    sw_data   = 16'h1234;
    #2 reset = 1'b0;
    #2;
    check_eq("rst_state",   64'(ia.state), 64'd0);
    check_eq("rst_idx",     64'(ia.op_idx), 64'd0);
    check_eq("rst_opnd",    64'(ia.operands), 64'd0);
    check_eq("rst_opcode",  64'(ia.opcode), 64'd0);
    check_eq("rst_result",  64'(ia.result), 64'd0);
    check_eq("rst_start",   64'(ia.alu_start), 64'd0);
    check_eq("rst_rvalid",  64'(ia.result_valid), 64'd0);
    check_eq("rst_terr",    64'(ia.timeout_err), 64'd0);
    check_eq("rst_display", 64'(ia.display_value), 64'h1234);
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    check_eq("held_idx",  64'(ia.op_idx), 64'd0);
    check_eq("held_opnd", 64'(ia.operands), 64'd0);
    btn_enter = 1'b0;
    tick(1);

    // main calculation
    press(1'b1, 16'h0012);
    check_eq("op0_idx", 64'(ia.op_idx), 64'd1);
    press(1'b1, 16'h0034);
    check_eq("op1_state", 64'(ia.state), 64'd1);
    check_eq("op1_opnd",  64'(ia.operands), 64'h0034_0012);
    sw_data = 16'hFFFB;
    #1;
    check_eq("wop_display", 64'(ia.display_value), 64'd3);
    sw_data   = 16'h0003;
    btn_enter = 1'b1;
    tick(1);
    check_eq("e0_state",   64'(ia.state), 64'd2);
    check_eq("e0_start",   64'(ia.alu_start), 64'd1);
    check_eq("e0_opcode",  64'(ia.opcode), 64'd3);
    check_eq("e0_display", 64'(ia.display_value), 64'd0);
    btn_enter = 1'b0;
    tick(1);
    check_eq("e1_start", 64'(ia.alu_start), 64'd0);
    check_eq("e1_state", 64'(ia.state), 64'd2);
    alu_done   = 1'b1;
    alu_result = 16'h0046;
    tick(1);
    alu_done = 1'b0;
    check_eq("show_state",   64'(ia.state), 64'd3);
    check_eq("show_result",  64'(ia.result), 64'h0046);
    check_eq("show_rvalid",  64'(ia.result_valid), 64'd1);
    check_eq("show_display", 64'(ia.display_value), 64'h0046);
    check_eq("show_terr",    64'(ia.timeout_err), 64'd0);
    alu_done   = 1'b1;
    alu_result = 16'h9999;
    tick(1);
    alu_done = 1'b0;
    check_eq("stray_done_result", 64'(ia.result), 64'h0046);
    check_eq("stray_done_state",  64'(ia.state), 64'd3);

    // back from SHOW and re-run with a new opcode, done in the start cycle
    press(1'b0, 16'h0000);
    check_eq("rerun_state",  64'(ia.state), 64'd1);
    check_eq("rerun_rvalid", 64'(ia.result_valid), 64'd0);
    sw_data   = 16'h0005;
    btn_enter = 1'b1;
    tick(1);
    check_eq("rerun_exec",   64'(ia.state), 64'd2);
    check_eq("rerun_opcode", 64'(ia.opcode), 64'd5);
    check_eq("rerun_start",  64'(ia.alu_start), 64'd1);
    check_eq("rerun_opnd",   64'(ia.operands), 64'h0034_0012);
    btn_enter  = 1'b0;
    alu_done   = 1'b1;
    alu_result = 16'h00AA;
    tick(1);
    alu_done = 1'b0;
    check_eq("fast_state",  64'(ia.state), 64'd3);
    check_eq("fast_result", 64'(ia.result), 64'h00AA);

    // timeout
    press(1'b1, 16'h0000);
    check_eq("new_state",  64'(ia.state), 64'd0);
    check_eq("new_idx",    64'(ia.op_idx), 64'd0);
    check_eq("new_rvalid", 64'(ia.result_valid), 64'd0);
    check_eq("new_opnd",   64'(ia.operands), 64'h0034_0012);
    press(1'b1, 16'h0001);
    press(1'b1, 16'h0002);
    sw_data   = 16'h0000;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(3);
    check_eq("to_still_exec", 64'(ia.state), 64'd2);
    tick(1);
    check_eq("to_state",  64'(ia.state), 64'd3);
    check_eq("to_result", 64'(ia.result), 64'hFFFF);
    check_eq("to_terr",   64'(ia.timeout_err), 64'd1);
    check_eq("to_rvalid", 64'(ia.result_valid), 64'd0);
    press(1'b0, 16'h0000);
    sw_data   = 16'h0006;
    btn_enter = 1'b1;
    tick(1);
    check_eq("terr_clear", 64'(ia.timeout_err), 64'd0);
    btn_enter  = 1'b0;
    alu_done   = 1'b1;
    alu_result = 16'h0001;
    tick(1);
    alu_done = 1'b0;
    press(1'b1, 16'h0000);

    // simultaneous and held buttons
    press(1'b1, 16'h7777);
    check_eq("sim_pre_idx", 64'(ia.op_idx), 64'd1);
    sw_data   = 16'h5555;
    btn_enter = 1'b1;
    btn_back  = 1'b1;
    tick(1);
    check_eq("sim_idx",  64'(ia.op_idx), 64'd0);
    check_eq("sim_opnd", 64'(ia.operands), 64'h0002_7777);
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    tick(1);
    sw_data   = 16'h1111;
    btn_enter = 1'b1;
    tick(50);
    btn_enter = 1'b0;
    tick(1);
    check_eq("hold_idx",   64'(ia.op_idx), 64'd1);
    check_eq("hold_state", 64'(ia.state), 64'd0);
    check_eq("hold_opnd",  64'(ia.operands), 64'h0002_1111);

    // async reset in the middle of EXEC
    press(1'b1, 16'h2222);
    sw_data   = 16'h0001;
    btn_enter = 1'b1;
    tick(1);
    check_eq("ar_exec", 64'(ia.state), 64'd2);
    btn_enter = 1'b0;
    reset = 1'b0;
    #2;
    check_eq("ar_state",  64'(ia.state), 64'd0);
    check_eq("ar_idx",    64'(ia.op_idx), 64'd0);
    check_eq("ar_opnd",   64'(ia.operands), 64'd0);
    check_eq("ar_opcode", 64'(ia.opcode), 64'd0);
    check_eq("ar_result", 64'(ia.result), 64'd0);
    check_eq("ar_start",  64'(ia.alu_start), 64'd0);
    check_eq("ar_rvalid", 64'(ia.result_valid), 64'd0);
    check_eq("ar_terr",   64'(ia.timeout_err), 64'd0);
    alu_done   = 1'b1;
    alu_result = 16'h3333;
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    check_eq("ar_late_done_state",  64'(ia.state), 64'd0);
    check_eq("ar_late_done_result", 64'(ia.result), 64'd0);
    alu_done = 1'b0;
    check_eq("b_rst_state", 64'(ib.state), 64'd0);

    // back navigation on the 3-operand instance
    press(1'b1, 16'h000A);
    check_eq("nav1", 64'(ib.op_idx), 64'd1);
    press(1'b1, 16'h000B);
    check_eq("nav2", 64'(ib.op_idx), 64'd2);
    press(1'b0, 16'h0000);
    check_eq("nav3", 64'(ib.op_idx), 64'd1);
    press(1'b0, 16'h0000);
    check_eq("nav4", 64'(ib.op_idx), 64'd0);
    press(1'b0, 16'h0000);
    check_eq("nav5", 64'(ib.op_idx), 64'd0);
    press(1'b1, 16'h0001);
    press(1'b1, 16'h0002);
    press(1'b1, 16'h0003);
    check_eq("nav_wop",  64'(ib.state), 64'd1);
    check_eq("nav_opnd", 64'(ib.operands), 64'h0003_0002_0001);
    press(1'b0, 16'h0000);
    check_eq("nav_back_state", 64'(ib.state), 64'd0);
    check_eq("nav_back_idx",   64'(ib.op_idx), 64'd2);
    check_eq("nav_back_opnd",  64'(ib.operands), 64'h0003_0002_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
